sound_wave_ram_arb: RTL and testbench
=====================================

SOUND_WAVE_RAM_ARB -- requirements
Module: sound_wave_ram_arb

Interface
REQ-001 The block SHALL have parameter CPU_MAX_WAIT, default 1: the number of cycles a pending CPU access may lose arbitration before it takes priority; legal range 1..3.
REQ-002 The block SHALL have port clk  input  1  main CPU clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port ch_active  input  1  channel 3 is currently playing.
REQ-005 The block SHALL have port play_req  input  1  one-cycle pulse: the player requests a sample byte.
REQ-006 The block SHALL have port play_addr  input  4  wave RAM byte address for play_req.
REQ-007 The block SHALL have port play_data  output  8  last byte fetched for the player.
REQ-008 The block SHALL have port play_valid  output  1  one-cycle pulse: play_data updated.
REQ-009 The block SHALL have port cpu_req  input  1  one-cycle pulse: CPU access request.
REQ-010 The block SHALL have port cpu_we  input  1  1 = write, 0 = read; sampled with cpu_req.
REQ-011 The block SHALL have port cpu_addr  input  4  CPU byte address (FF30-FF3F offset).
REQ-012 The block SHALL have port cpu_wdata  input  8  CPU write data.
REQ-013 The block SHALL have port cpu_rdata  output  8  CPU read data, valid while cpu_ack is high.
REQ-014 The block SHALL have port cpu_ack  output  1  one-cycle pulse: CPU access complete.
REQ-015 The block SHALL have port cpu_busy  output  1  a CPU access is pending; new cpu_req is ignored.

Function
REQ-016 The block SHALL contain a 16x8 single-port wave RAM, one access (read or write) per cycle, with a registered read (1 cycle).
REQ-017 play_req and cpu_req SHALL be captured, with their address and data, into pending registers on the cycle they are asserted.
REQ-018 A play_req arriving while a player request is still pending SHALL replace the pending address; only one player request is outstanding.
REQ-019 A cpu_req arriving while cpu_busy=1 SHALL be dropped without effect.
REQ-020 Arbitration SHALL happen every cycle among pending requests plus requests asserted that cycle; the player wins unless the CPU wait counter equals CPU_MAX_WAIT, in which case the CPU wins.
REQ-021 The CPU wait counter SHALL increment on each cycle a pending CPU request loses, and SHALL clear when the CPU is granted.
REQ-022 Player grant at cycle N SHALL produce play_data = RAM[addr] and play_valid=1 at cycle N+1.
REQ-023 CPU write grant at cycle N SHALL update RAM at N and pulse cpu_ack at N+1; CPU read grant at N SHALL present cpu_rdata with cpu_ack at N+1.
REQ-024 An uncontended request SHALL be granted in its request cycle, so latency to play_valid/cpu_ack is 1 cycle.
REQ-025 The worst-case CPU latency SHALL be CPU_MAX_WAIT+1 cycles.
REQ-026 cpu_busy SHALL be high from the cycle after cpu_req is captured until the cycle of cpu_ack inclusive.
REQ-027 A read and a write to the same address granted in consecutive cycles SHALL return the newly written value.
REQ-028 cpu_rdata and play_data SHALL hold their values between acknowledgements.

Reset
REQ-029 On rst_n=0 the block SHALL immediately clear both pending flags and the wait counter, and drive play_data=0x00, play_valid=0, cpu_rdata=0x00, cpu_ack=0 and cpu_busy=0.
REQ-030 Wave RAM contents SHALL NOT be altered by reset; a request in flight at reset SHALL be discarded without an ack.

Configuration
REQ-031 With macro SOUND_WAVE_DMG_QUIRK_EN defined and ch_active=1, CPU reads SHALL return the last player-fetched byte and CPU writes SHALL target the last player-fetched address, with cpu_addr ignored; arbitration and latency SHALL be unchanged.
REQ-032 Without SOUND_WAVE_DMG_QUIRK_EN, or with ch_active=0, CPU accesses SHALL use cpu_addr directly.

Verification
REQ-033 CPU write 0xA5 to addr 3, then a CPU read of addr 3 -> cpu_ack 1 cycle after each request, and cpu_rdata=0xA5.
REQ-034 play_req addr 3 and cpu_req read addr 7 in the same cycle, CPU_MAX_WAIT=1 -> play_valid with 0xA5 at N+1, and cpu_ack at N+2.
REQ-035 play_req asserted every cycle and cpu_req at N, CPU_MAX_WAIT=2 -> CPU granted at N+2 and cpu_ack at N+3; cpu_req at N+1 is dropped.
REQ-036 rst_n low for 1 cycle while a CPU read is pending -> no cpu_ack; all outputs are 0; RAM addr 3 still reads 0xA5 after reset.
REQ-037 With the quirk enabled and ch_active=1, last player fetch at addr 5 (0x3C), CPU read addr 0 -> cpu_rdata=0x3C; CPU write 0x11 to addr 0 -> RAM[5]=0x11 and RAM[0] unchanged.

Source files
------------

// File: rtl/sound_wave_ram_arb.sv
// Wave RAM arbiter: player and CPU share a 16x8 single-port RAM, player first, CPU forced after CPU_MAX_WAIT losses.
// Optional SOUND_WAVE_DMG_QUIRK_EN: while ch_active, CPU accesses hit the last player-fetched byte/address.
module sound_wave_ram_arb #(
    parameter int CPU_MAX_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ch_active,
    input  logic       play_req,
    input  logic [3:0] play_addr,
    output logic [7:0] play_data,
    output logic       play_valid,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [3:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ack,
    output logic       cpu_busy
);

`ifdef SOUND_WAVE_DMG_QUIRK_EN
    localparam logic QUIRK_EN = 1'b1;
`else
    localparam logic QUIRK_EN = 1'b0;
`endif
    localparam logic [1:0] MAX_WAIT = 2'(CPU_MAX_WAIT);

    logic [7:0] mem [16];

    logic       play_pend;
    logic [3:0] play_pend_addr;
    logic       cpu_pend;
    logic       cpu_pend_we;
    logic [3:0] cpu_pend_addr;
    logic [7:0] cpu_pend_wdata;
    logic [1:0] wait_cnt;
    logic [3:0] last_play_addr;

    logic       play_v;
    logic [3:0] play_a;
    logic       cpu_accept;
    logic       cpu_v;
    logic       cpu_w;
    logic [3:0] cpu_a;
    logic [7:0] cpu_d;
    logic       cpu_grant;
    logic       play_grant;
    logic       quirk_on;
    logic [3:0] cpu_mem_addr;

    // A fresh play_req replaces whatever address is still pending.
    always_comb begin
        play_v       = play_req | play_pend;
        play_a       = play_req ? play_addr : play_pend_addr;
        cpu_accept   = cpu_req & ~cpu_busy;
        cpu_v        = cpu_pend | cpu_accept;
        cpu_w        = cpu_pend ? cpu_pend_we    : cpu_we;
        cpu_a        = cpu_pend ? cpu_pend_addr  : cpu_addr;
        cpu_d        = cpu_pend ? cpu_pend_wdata : cpu_wdata;
        cpu_grant    = cpu_v & (~play_v | (wait_cnt == MAX_WAIT));
        play_grant   = play_v & ~cpu_grant;
        quirk_on     = QUIRK_EN & ch_active;
        cpu_mem_addr = quirk_on ? last_play_addr : cpu_a;
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (cpu_grant && cpu_w) begin
            mem[cpu_mem_addr] <= cpu_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            play_pend      <= 1'b0;
            play_pend_addr <= 4'h0;
            cpu_pend       <= 1'b0;
            cpu_pend_we    <= 1'b0;
            cpu_pend_addr  <= 4'h0;
            cpu_pend_wdata <= 8'h00;
            wait_cnt       <= 2'd0;
            last_play_addr <= 4'h0;
            play_data      <= 8'h00;
            play_valid     <= 1'b0;
            cpu_rdata      <= 8'h00;
            cpu_ack        <= 1'b0;
            cpu_busy       <= 1'b0;
        end else begin
            play_pend      <= play_v & ~play_grant;
            play_pend_addr <= play_a;
            cpu_pend       <= cpu_v & ~cpu_grant;
            cpu_pend_we    <= cpu_w;
            cpu_pend_addr  <= cpu_a;
            cpu_pend_wdata <= cpu_d;
            play_valid     <= play_grant;
            cpu_ack        <= cpu_grant;

            if (cpu_grant) begin
                wait_cnt <= 2'd0;
            end else if (cpu_v) begin
                wait_cnt <= wait_cnt + 2'd1;
            end

            if (play_grant) begin
                play_data      <= mem[play_a];
                last_play_addr <= play_a;
            end

            if (cpu_grant && !cpu_w) begin
                cpu_rdata <= quirk_on ? play_data : mem[cpu_mem_addr];
            end

            // Busy from the cycle after capture through the ack cycle.
            if (cpu_accept) begin
                cpu_busy <= 1'b1;
            end else if (cpu_ack) begin
                cpu_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sound_wave_ram_arb.sv
// Directed bench for sound_wave_ram_arb: two instances (CPU_MAX_WAIT=1 and 2) driven by the same stimulus.
module tb_sound_wave_ram_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ch_active;
    logic       play_req;
    logic [3:0] play_addr;
    logic       cpu_req;
    logic       cpu_we;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata;

    logic [7:0] play_data1, cpu_rdata1, play_data2, cpu_rdata2;
    logic       play_valid1, cpu_ack1, cpu_busy1;
    logic       play_valid2, cpu_ack2, cpu_busy2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sound_wave_ram_arb #(.CPU_MAX_WAIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ch_active(ch_active),
        .play_req(play_req), .play_addr(play_addr),
        .play_data(play_data1), .play_valid(play_valid1),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1), .cpu_busy(cpu_busy1)
    );

    sound_wave_ram_arb #(.CPU_MAX_WAIT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ch_active(ch_active),
        .play_req(play_req), .play_addr(play_addr),
        .play_data(play_data2), .play_valid(play_valid2),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata2), .cpu_ack(cpu_ack2), .cpu_busy(cpu_busy2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        play_req  = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        play_addr = 4'h0;
        cpu_addr  = 4'h0;
        cpu_wdata = 8'h00;
    endtask

    // Uncontended CPU access: one cycle to ack, then ack and busy drop.
    task automatic cpu_access(input logic we, input logic [3:0] a, input logic [7:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        step();
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        ch_active = 1'b0;
        idle_inputs();
        #12;
        check("rst_play_data", play_data1, 8'h00);
        check("rst_play_valid", play_valid1, 1'b0);
        check("rst_cpu_rdata", cpu_rdata1, 8'h00);
        check("rst_cpu_ack", cpu_ack1, 1'b0);
        check("rst_cpu_busy", cpu_busy1, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // Write A5 to 3, read it back; single-cycle latency each way.
        cpu_access(1'b1, 4'd3, 8'hA5);
        check("wr3_ack", cpu_ack1, 1'b1);
        check("wr3_busy", cpu_busy1, 1'b1);
        step();
        check("wr3_ack_drop", cpu_ack1, 1'b0);
        check("wr3_busy_drop", cpu_busy1, 1'b0);
        cpu_access(1'b0, 4'd3, 8'h00);
        check("rd3_ack", cpu_ack1, 1'b1);
        check("rd3_data", cpu_rdata1, 8'hA5);
        step();
        check("rd3_ack_drop", cpu_ack1, 1'b0);
        check("rd3_hold", cpu_rdata1, 8'hA5);

        cpu_access(1'b1, 4'd7, 8'h5A); step();
        cpu_access(1'b1, 4'd5, 8'h3C); step();
        cpu_access(1'b1, 4'd0, 8'h77); step();

        // Same-cycle player and CPU: player first, CPU one cycle later.
        play_req = 1'b1; play_addr = 4'd3;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd7;
        step();
        idle_inputs();
        check("c34_play_valid", play_valid1, 1'b1);
        check("c34_play_data", play_data1, 8'hA5);
        check("c34_cpu_ack_early", cpu_ack1, 1'b0);
        check("c34_cpu_busy", cpu_busy1, 1'b1);
        step();
        check("c34_cpu_ack", cpu_ack1, 1'b1);
        check("c34_cpu_rdata", cpu_rdata1, 8'h5A);
        check("c34_play_valid_drop", play_valid1, 1'b0);
        check("c34_play_data_hold", play_data1, 8'hA5);
        step();
        check("c34_ack_drop", cpu_ack1, 1'b0);

        // Player every cycle; CPU read at N wins at N+2 (MAX_WAIT=2), write at N+1 dropped.
        play_req = 1'b1; play_addr = 4'd3;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd7;
        step();
        check("c35_n_ack", cpu_ack2, 1'b0);
        check("c35_n_busy", cpu_busy2, 1'b1);
        check("c35_n_play_valid", play_valid2, 1'b1);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd7; cpu_wdata = 8'hFF;
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;
        check("c35_n1_ack", cpu_ack2, 1'b0);
        check("c35_mw1_ack", cpu_ack1, 1'b1);
        step();
        check("c35_n2_ack", cpu_ack2, 1'b1);
        check("c35_n2_rdata", cpu_rdata2, 8'h5A);
        check("c35_n2_play_valid", play_valid2, 1'b0);
        step();
        play_req = 1'b0;
        check("c35_n3_ack_drop", cpu_ack2, 1'b0);
        check("c35_n3_play_valid", play_valid2, 1'b1);
        check("c35_n3_busy", cpu_busy2, 1'b0);
        step();
        check("c35_play_idle", play_valid2, 1'b0);
        cpu_access(1'b0, 4'd7, 8'h00);
        check("c35_dropped_wr2", cpu_rdata2, 8'h5A);
        check("c35_dropped_wr1", cpu_rdata1, 8'h5A);
        step();

        // Reset with a CPU read stuck behind the player.
        play_req = 1'b1; play_addr = 4'd0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd3;
        step();
        idle_inputs();
        check("c36_pending_busy", cpu_busy1, 1'b1);
        rst_n = 1'b0;
        #1;
        check("c36_async_play_valid", play_valid1, 1'b0);
        check("c36_async_play_data", play_data1, 8'h00);
        check("c36_async_busy", cpu_busy1, 1'b0);
        check("c36_async_rdata", cpu_rdata1, 8'h00);
        step();
        rst_n = 1'b1;
        step();
        check("c36_no_ack", cpu_ack1, 1'b0);
        step();
        check("c36_no_ack2", cpu_ack1, 1'b0);
        cpu_access(1'b0, 4'd3, 8'h00);
        check("c36_ram_kept", cpu_rdata1, 8'hA5);
        step();

        // ch_active redirect: quirk builds use last player fetch, others use cpu_addr.
        ch_active = 1'b1;
        play_req = 1'b1; play_addr = 4'd5;
        step();
        idle_inputs();
        check("c37_play_fetch", play_data1, 8'h3C);
        step();
        cpu_access(1'b0, 4'd0, 8'h00);
        check("c37_rd_ack", cpu_ack1, 1'b1);
`ifdef SOUND_WAVE_DMG_QUIRK_EN
        check("c37_rd_quirk", cpu_rdata1, 8'h3C);
`else
        check("c37_rd_direct", cpu_rdata1, 8'h77);
`endif
        step();
        cpu_access(1'b1, 4'd0, 8'h11);
        check("c37_wr_ack", cpu_ack1, 1'b1);
        step();
        ch_active = 1'b0;
        cpu_access(1'b0, 4'd5, 8'h00);
`ifdef SOUND_WAVE_DMG_QUIRK_EN
        check("c37_ram5", cpu_rdata1, 8'h11);
`else
        check("c37_ram5", cpu_rdata1, 8'h3C);
`endif
        step();
        cpu_access(1'b0, 4'd0, 8'h00);
`ifdef SOUND_WAVE_DMG_QUIRK_EN
        check("c37_ram0", cpu_rdata1, 8'h77);
`else
        check("c37_ram0", cpu_rdata1, 8'h11);
`endif
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
